spi_regbank_p: RTL and testbench
================================

SPI_REGBANK_P -- requirements
Module: spi_regbank_p

Interface
REQ-001 Parameter NUM_CH, default 8: number of read-only channel words.
REQ-002 Parameter CH_WIDTH, default 50: bits per channel word; BPC = ceil(CH_WIDTH/8) bytes per channel.
REQ-003 Parameter NUM_RW, default 3: number of 8-bit read/write registers.
REQ-004 sclk  input  1  sole clock; all state changes on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 cs_n  input  1  frame select, sampled on sclk; high = idle/abort frame.
REQ-007 serial_in  input  1  serial data in, LSB first.
REQ-008 serial_out  output  1  serial data out, LSB first, registered.
REQ-009 ch_data  input  NUM_CH*CH_WIDTH  channel words, channel c at [c*CH_WIDTH +: CH_WIDTH].
REQ-010 rw_regs  output  NUM_RW*8  register contents, register k (1-based) at [(k-1)*8 +: 8].
REQ-011 wr_stb  output  1  one-cycle pulse on each committed register write.
REQ-012 wr_idx  output  8  address of the register written; valid when wr_stb high.
REQ-013 addr_err  output  1  sticky flag: a data byte addressed an invalid location.

Function
REQ-014 Address map: 0 = reserved; 1..NUM_RW = RW registers; RO_BASE = NUM_RW+1; channel c byte b at RO_BASE + c*BPC + b; addresses >= RO_BASE + NUM_CH*BPC invalid (defaults: RO 4..59, invalid 60..255).
REQ-015 States: ADDR (shift 8-bit address) and DATA (shift data bytes); 3-bit bit counter per byte.
REQ-016 ADDR: 8 rising edges with cs_n low shift serial_in LSB first; on the 8th edge pointer <= shifted byte, snapshot all ch_data into internal shadow, go to DATA.
REQ-017 DATA: on bit-j edge (j = 0..7) serial_out <= read_byte(pointer)[j] while serial_in is shifted in.
REQ-018 read_byte: RW register value; RO byte from shadow, bits beyond CH_WIDTH in last byte read 0; address 0 and invalid addresses read 0x00.
REQ-019 On the 8th edge of a data byte: if pointer in 1..NUM_RW, register <= received byte, wr_stb = 1 next cycle, wr_idx = pointer; RO/reserved writes ignored.
REQ-020 On the 8th edge of a data byte at an invalid pointer, addr_err <= 1.
REQ-021 Pointer increments after every completed data byte, saturating at 255 (no wrap to 0).
REQ-022 Shadow stays frozen for the whole frame; ch_data changes mid-frame are not visible until the next address byte.
REQ-023 cs_n high on any edge: bit counter <= 0, state <= ADDR, serial_out <= 0, partial byte discarded, no write; rw_regs, addr_err retained.
REQ-024 serial_out = 0 throughout ADDR state.

Reset
REQ-025 rstn low asynchronously sets: state ADDR, bit counter 0, pointer 0, rw_regs all 0, shadow 0, serial_out 0, wr_stb 0, wr_idx 0, addr_err 0.
REQ-026 Reset mid-byte discards the byte; first edge after release is bit 0 of an address byte (if cs_n low).

Structure
REQ-027 Shared package holds state enum (ADDR, DATA), address-map function computing RO_BASE/BPC/limit, and reserved-read constant 0x00.
REQ-028 One sub-module spi_byte_shifter (8-bit shift-in register plus bit counter, byte_done pulse) is natural; FSM, map decode and register file remain in the top.

Verification
REQ-029 Defaults; addr 0x01 then write 0x10,0x20,0x30; cs_n pulse; addr 0x01 then three bytes -> reads 0x10,0x20,0x30; wr_stb pulsed 3+3 times with wr_idx 1,2,3.
REQ-030 ch0 = 0x2D2D2D2D2D2D3; addr 0x04, 7 data bytes -> 0xD3,0xD2,0xD2,0xD2,0xD2,0xD2,0x02; continue 56 bytes total covering ch0..ch7 byte-exact.
REQ-031 Addr 0x3C..0xFF each followed by one byte -> read 0x00, rw_regs unchanged, addr_err = 1 after first.
REQ-032 Addr 0x04, change ch_data after first byte -> remaining bytes still from snapshot value.
REQ-033 Addr 0x02, assert cs_n after 4 data bits -> register 2 unchanged, no wr_stb; next frame starts cleanly in ADDR.
REQ-034 NUM_CH=4, CH_WIDTH=12, NUM_RW=2: RO_BASE 3, BPC 2, addr 11 invalid; ch byte 1 upper 4 bits read 0.

Source files
------------

// File: rtl/spi_regbank_p_pkg.sv
// Shared types and address-map helpers for the SPI register bank.
package spi_regbank_p_pkg;
  typedef enum logic {ST_ADDR, ST_DATA} state_t;

  localparam logic [7:0] RSVD_RD = 8'h00;

  function automatic int calc_bpc(input int w);
    return (w + 7) / 8;
  endfunction

  function automatic int calc_ro_base(input int num_rw);
    return num_rw + 1;
  endfunction

  // First address past the read-only window; everything at or above it is invalid.
  function automatic int calc_ro_lim(input int num_rw, input int num_ch, input int w);
    return num_rw + 1 + num_ch * calc_bpc(w);
  endfunction
endpackage

// File: rtl/spi_byte_shifter.sv
// LSB-first serial byte assembler with bit counter; byte_done marks the 8th edge.
module spi_byte_shifter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       din,
  output logic [2:0] bit_cnt,
  output logic [7:0] byte_nxt,
  output logic       byte_done
);
  // Only 7 bits are stored; the 8th bit is taken straight from din on the final edge.
  logic [6:0] sreg;

  assign byte_nxt  = {din, sreg};
  assign byte_done = !clr && (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= 3'd0;
      sreg    <= 7'd0;
    end else if (clr) begin
      bit_cnt <= 3'd0;
      sreg    <= 7'd0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      sreg    <= {din, sreg[6:1]};
    end
  end
endmodule

// File: rtl/spi_regbank_p.sv
// SPI-style register bank: RW byte registers plus frame-snapshotted read-only channels.
module spi_regbank_p
  import spi_regbank_p_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int CH_WIDTH = 50,
  parameter int NUM_RW   = 3
) (
  input  logic                         sclk,
  input  logic                         rstn,
  input  logic                         cs_n,
  input  logic                         serial_in,
  output logic                         serial_out,
  input  logic [NUM_CH*CH_WIDTH-1:0]   ch_data,
  output logic [NUM_RW*8-1:0]          rw_regs,
  output logic                         wr_stb,
  output logic [7:0]                   wr_idx,
  output logic                         addr_err
);
  localparam int BPC     = calc_bpc(CH_WIDTH);
  localparam int RO_BASE = calc_ro_base(NUM_RW);
  localparam int RO_LIM  = calc_ro_lim(NUM_RW, NUM_CH, CH_WIDTH);
  localparam int NBYTES  = NUM_CH * BPC;
  localparam int OW      = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [7:0] RO_BASE8 = 8'(RO_BASE);

  state_t                      state;
  logic [7:0]                  ptr;
  logic [NUM_RW-1:0][7:0]      regs;
  logic [NUM_CH*CH_WIDTH-1:0]  shadow;
  logic [NBYTES*8-1:0]         ro_flat;
  logic [2:0]                  bit_cnt;
  logic [7:0]                  byte_nxt;
  logic                        byte_done;
  logic                        rw_hit, ro_hit, inv;
  logic [OW-1:0]               ro_off;
  logic [7:0]                  rd_byte;

  spi_byte_shifter u_shift (
    .clk       (sclk),
    .rst_n     (rstn),
    .clr       (cs_n),
    .din       (serial_in),
    .bit_cnt   (bit_cnt),
    .byte_nxt  (byte_nxt),
    .byte_done (byte_done)
  );

  // Each channel is zero-padded to a whole number of bytes so high bits read 0.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ro
    assign ro_flat[c*BPC*8 +: BPC*8] = (BPC*8)'(shadow[c*CH_WIDTH +: CH_WIDTH]);
  end

  assign rw_regs = regs;
  assign rw_hit  = (ptr != 8'd0) && (int'(ptr) <= NUM_RW);
  assign ro_hit  = (int'(ptr) >= RO_BASE) && (int'(ptr) < RO_LIM);
  assign inv     = int'(ptr) >= RO_LIM;
  assign ro_off  = OW'(ptr - RO_BASE8);

  always_comb begin
    rd_byte = RSVD_RD;
    if (rw_hit) begin
      for (int k = 0; k < NUM_RW; k++)
        if (ptr == 8'(k + 1)) rd_byte = regs[k];
    end else if (ro_hit) begin
      rd_byte = ro_flat[{ro_off, 3'b000} +: 8];
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_ADDR;
      ptr        <= 8'd0;
      regs       <= '0;
      shadow     <= '0;
      serial_out <= 1'b0;
      wr_stb     <= 1'b0;
      wr_idx     <= 8'd0;
      addr_err   <= 1'b0;
    end else begin
      wr_stb <= 1'b0;
      if (cs_n) begin
        state      <= ST_ADDR;
        serial_out <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            serial_out <= 1'b0;
            if (byte_done) begin
              ptr    <= byte_nxt;
              shadow <= ch_data;
              state  <= ST_DATA;
            end
          end
          ST_DATA: begin
            serial_out <= rd_byte[bit_cnt];
            if (byte_done) begin
              if (rw_hit) begin
                for (int k = 0; k < NUM_RW; k++)
                  if (ptr == 8'(k + 1)) regs[k] <= byte_nxt;
                wr_stb <= 1'b1;
                wr_idx <= ptr;
              end
              if (inv) addr_err <= 1'b1;
              // Saturate so a long burst never wraps back onto the registers.
              if (ptr != 8'hFF) ptr <= ptr + 8'd1;
            end
          end
          default: state <= ST_ADDR;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_regbank_p.sv
// Directed bench for spi_regbank_p: default instance plus a small-parameter instance.
module tb_spi_regbank_p;
  logic sclk = 1'b0, rstn = 1'b0, cs_n = 1'b1, serial_in = 1'b0;
  logic [8*50-1:0] ch_data = '0;
  logic [4*12-1:0] ch_data_s = '0;
  logic serial_out, wr_stb, addr_err;
  logic [23:0] rw_regs;
  logic [7:0]  wr_idx;
  logic serial_out_s, wr_stb_s, addr_err_s;
  logic [15:0] rw_regs_s;
  logic [7:0]  wr_idx_s;

  spi_regbank_p u_dut (
    .sclk(sclk), .rstn(rstn), .cs_n(cs_n), .serial_in(serial_in),
    .serial_out(serial_out), .ch_data(ch_data), .rw_regs(rw_regs),
    .wr_stb(wr_stb), .wr_idx(wr_idx), .addr_err(addr_err)
  );

  spi_regbank_p #(.NUM_CH(4), .CH_WIDTH(12), .NUM_RW(2)) u_small (
    .sclk(sclk), .rstn(rstn), .cs_n(cs_n), .serial_in(serial_in),
    .serial_out(serial_out_s), .ch_data(ch_data_s), .rw_regs(rw_regs_s),
    .wr_stb(wr_stb_s), .wr_idx(wr_idx_s), .addr_err(addr_err_s)
  );

  always #5 sclk = ~sclk;

  int checks = 0, errors = 0, stb_cnt = 0;
  logic [7:0] idx_q[$];

  always @(negedge sclk)
    if (wr_stb === 1'b1) begin
      stb_cnt++;
      idx_q.push_back(wr_idx);
    end

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic xbyte(input logic [7:0] tx, output logic [7:0] rx, output logic [7:0] rxs);
    for (int j = 0; j < 8; j++) begin
      cs_n = 1'b0;
      serial_in = tx[j];
      @(posedge sclk);
      @(negedge sclk);
      rx[j]  = serial_out;
      rxs[j] = serial_out_s;
    end
  endtask

  task automatic idle();
    cs_n = 1'b1;
    serial_in = 1'b0;
    @(posedge sclk);
    @(negedge sclk);
  endtask

  logic [49:0] ch [8];
  logic [7:0]  wv [3] = '{8'h10, 8'h20, 8'h30};
  logic [7:0]  e0 [7] = '{8'hD3, 8'hD2, 8'hD2, 8'hD2, 8'hD2, 8'hD2, 8'h02};
  logic [7:0]  rx, rxs;
  logic [55:0] t;
  int          s0;

  task automatic pack_ch();
    for (int c = 0; c < 8; c++) ch_data[c*50 +: 50] = ch[c];
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_so", serial_out, 0);
    chk("rst_regs", rw_regs, 0);
    chk("rst_stb", wr_stb, 0);
    chk("rst_idx", wr_idx, 0);
    chk("rst_err", addr_err, 0);
    @(negedge sclk); rstn = 1'b1; @(negedge sclk);

    // RW write burst then read-back burst
    xbyte(8'h01, rx, rxs); chk("addr_so0", rx, 0);
    for (int i = 0; i < 3; i++) begin xbyte(wv[i], rx, rxs); chk("rw_old", rx, 0); end
    idle();
    chk("idle_so", serial_out, 0);
    chk("rw_wr", rw_regs, 24'h302010);
    chk("stb3", stb_cnt, 3);
    xbyte(8'h01, rx, rxs);
    for (int i = 0; i < 3; i++) begin xbyte(wv[i], rx, rxs); chk("rw_rd", rx, wv[i]); end
    idle();
    chk("stb6", stb_cnt, 6);
    for (int i = 0; i < 6; i++) chk("wr_idx", idx_q[i], (i % 3) + 1);

    // Full read-only sweep across all eight channels
    ch[0] = 50'h2D2D2D2D2D2D3;
    for (int c = 1; c < 8; c++) ch[c] = {$urandom, $urandom};
    pack_ch();
    s0 = stb_cnt;
    xbyte(8'h04, rx, rxs);
    for (int i = 0; i < 56; i++) begin
      xbyte(8'h00, rx, rxs);
      if (i < 7) chk("ch0_byte", rx, e0[i]);
      else begin
        t = 56'(ch[i / 7]);
        chk("ro_byte", rx, t[8*(i % 7) +: 8]);
      end
    end
    idle();
    chk("ro_err", addr_err, 0);
    chk("ro_regs", rw_regs, 24'h302010);
    chk("ro_nostb", stb_cnt, s0);

    // Shadow frozen within a frame
    xbyte(8'h04, rx, rxs);
    xbyte(8'h00, rx, rxs); chk("snap0", rx, 8'hD3);
    ch[0] = '0; pack_ch();
    xbyte(8'h00, rx, rxs); chk("snap1", rx, 8'hD2);
    xbyte(8'h00, rx, rxs); chk("snap2", rx, 8'hD2);
    idle();
    xbyte(8'h04, rx, rxs);
    xbyte(8'h00, rx, rxs); chk("snap_new", rx, 8'h00);
    idle();

    // Aborted write: 4 bits then cs_n high
    s0 = stb_cnt;
    xbyte(8'h02, rx, rxs);
    for (int j = 0; j < 4; j++) begin
      serial_in = 1'b1; @(posedge sclk); @(negedge sclk);
    end
    idle();
    chk("abort_so", serial_out, 0);
    chk("abort_regs", rw_regs, 24'h302010);
    chk("abort_nostb", stb_cnt, s0);
    xbyte(8'h02, rx, rxs); chk("abort_addr_so", rx, 0);
    xbyte(8'h20, rx, rxs); chk("abort_rd", rx, 8'h20);
    idle();

    // Reserved address 0
    s0 = stb_cnt;
    xbyte(8'h00, rx, rxs);
    xbyte(8'h5A, rx, rxs); chk("rsvd_rd", rx, 0);
    idle();
    chk("rsvd_nostb", stb_cnt, s0);
    chk("rsvd_err", addr_err, 0);

    // Invalid addresses 0x3C..0xFF
    for (int a = 8'h3C; a <= 8'hFF; a++) begin
      xbyte(8'(a), rx, rxs);
      xbyte(8'hA5, rx, rxs); chk("inv_rd", rx, 0);
      idle();
      if (a == 8'h3C) chk("inv_err1", addr_err, 1);
    end
    chk("inv_regs", rw_regs, 24'h302010);
    chk("inv_nostb", stb_cnt, s0);
    chk("inv_err", addr_err, 1);

    // Reset mid address byte, then small-parameter instance
    cs_n = 1'b0;
    for (int j = 0; j < 3; j++) begin
      serial_in = 1'b1; @(posedge sclk); @(negedge sclk);
    end
    rstn = 1'b0;
    #1;
    chk("mrst_regs", rw_regs, 0);
    chk("mrst_err", addr_err, 0);
    chk("mrst_err_s", addr_err_s, 0);
    ch_data_s = {12'hF0F, 12'h456, 12'hABC, 12'h123};
    @(negedge sclk); rstn = 1'b1;
    xbyte(8'h05, rx, rxs); chk("s_addr_so", rxs, 0);
    xbyte(8'h00, rx, rxs); chk("s_ch1b0", rxs, 8'hBC);
    xbyte(8'h00, rx, rxs); chk("s_ch1b1", rxs, 8'h0A);
    xbyte(8'h00, rx, rxs); chk("s_ch2b0", rxs, 8'h56);
    xbyte(8'h00, rx, rxs); chk("s_ch2b1", rxs, 8'h04);
    idle();
    xbyte(8'h0A, rx, rxs);
    xbyte(8'h00, rx, rxs); chk("s_ch3b1", rxs, 8'h0F);
    chk("s_err0", addr_err_s, 0);
    xbyte(8'h00, rx, rxs); chk("s_inv_rd", rxs, 0);
    idle();
    chk("s_err1", addr_err_s, 1);
    xbyte(8'h02, rx, rxs);
    xbyte(8'h77, rx, rxs);
    idle();
    chk("s_regs", rw_regs_s, 16'h7700);
    chk("s_big_regs", rw_regs, 24'h007700);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
